sprite_compositor: RTL and testbench

Parametrised multi-sprite compositor between the VGA controller's DrawX/DrawY and the colour mapper. Holds position, frame, flip and animation attributes for NUM_SPR sprite channels. Attributes are double-buffered: software writes a pending set, which becomes active on each frame start. Per pixel, the block drives one address per channel to external synchronous sprite ROMs, drops transparent texels, resolves priority, and returns a single colour and hit flag with fixed latency.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/sprite_compositor_if.sv | 41 ++++
 rtl/sprite_channel.sv | 66 ++++++
 rtl/sprite_compositor.sv | 141 ++++++++++++++
 tb/tb_sprite_compositor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types, widths and helpers for the sprite compositor and its channels.
// Widths are derived from the default geometry; instances must use the same geometry.
package sprite_pkg;

    localparam int DEF_NUM_SPR    = 4;
    localparam int DEF_SPR_W      = 26;
    localparam int DEF_SPR_H      = 32;
    localparam int DEF_NUM_FRAMES = 8;
    localparam int DEF_COORD_W    = 10;
    localparam int DEF_COLOR_W    = 24;

    localparam int ADDR_W = $clog2(DEF_NUM_FRAMES * DEF_SPR_W * DEF_SPR_H);
    localparam int IDX_W  = $clog2(DEF_NUM_SPR);
    localparam int FRM_W  = $clog2(DEF_NUM_FRAMES);

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [FRM_W-1:0]       frame;
        logic                   flip;
        logic                   vis;
        logic                   anim;
    } spr_attr_t;

    // Two guard bits keep frame + phase from wrapping before the modulo.
    function automatic logic [FRM_W-1:0] eff_frame(
        input logic [FRM_W-1:0] frame,
        input logic             anim,
        input logic [FRM_W-1:0] phase,
        input int               num_frames
    );
        logic [FRM_W+1:0] sum;
        logic [FRM_W+1:0] nf;
        sum = {2'b00, frame} + (anim ? {2'b00, phase} : '0);
        nf  = num_frames[FRM_W+1:0];
        return FRM_W'(sum % nf);
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel, attribute-write, sprite-ROM and composite-output signals of the compositor.
// The DUT side uses the slave modport; the source of pixels/writes uses master.
interface sprite_compositor_if #(
    parameter int NUM_SPR = sprite_pkg::DEF_NUM_SPR,
    parameter int COORD_W = sprite_pkg::DEF_COORD_W,
    parameter int COLOR_W = sprite_pkg::DEF_COLOR_W
);
    import sprite_pkg::*;

    // No valid/ready pairs: wr_en and frame_start are single-cycle strobes that are
    // always accepted on the edge they are high; DrawX/DrawY advance one pixel per clock.
    logic                        frame_start;
    logic                        wr_en;
    logic [IDX_W-1:0]            wr_idx;
    logic [COORD_W-1:0]          wr_x;
    logic [COORD_W-1:0]          wr_y;
    logic [FRM_W-1:0]            wr_frame;
    logic                        wr_flip;
    logic                        wr_vis;
    logic                        wr_anim;
    logic [COORD_W-1:0]          DrawX;
    logic [COORD_W-1:0]          DrawY;
    logic [NUM_SPR*ADDR_W-1:0]   rom_addr;
    logic [NUM_SPR*COLOR_W-1:0]  rom_data;
    logic                        spr_hit;
    logic [IDX_W-1:0]            spr_id;
    logic [COLOR_W-1:0]          spr_color;

    modport slave (
        input  frame_start, wr_en, wr_idx, wr_x, wr_y, wr_frame, wr_flip, wr_vis, wr_anim,
        input  DrawX, DrawY, rom_data,
        output rom_addr, spr_hit, spr_id, spr_color
    );

    modport master (
        output frame_start, wr_en, wr_idx, wr_x, wr_y, wr_frame, wr_flip, wr_vis, wr_anim,
        output DrawX, DrawY, rom_data,
        input  rom_addr, spr_hit, spr_id, spr_color
    );

endinterface

// File: rtl/sprite_channel.sv
// One sprite channel: hit test and ROM address for the current pixel.
// The address goes straight to the synchronous ROM; the hit bit is registered to align with its data.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int COORD_W    = DEF_COORD_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  spr_attr_t          attr,
    input  logic [FRM_W-1:0]   phase,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               hit,
    output logic [ADDR_W-1:0]  rom_addr
);

    localparam int CW1        = COORD_W + 1;
    localparam int COL_MAX_I  = SPR_W - 1;
    localparam int FRAME_SZ_I = SPR_W * SPR_H;

    localparam logic [COORD_W-1:0] COL_MAX  = COL_MAX_I[COORD_W-1:0];
    localparam logic [CW1-1:0]     SPR_W_C  = CW1'(SPR_W);
    localparam logic [CW1-1:0]     SPR_H_C  = CW1'(SPR_H);
    localparam logic [ADDR_W-1:0]  FRAME_SZ = ADDR_W'(FRAME_SZ_I);
    localparam logic [ADDR_W-1:0]  ROW_SZ   = ADDR_W'(SPR_W);

    logic [CW1-1:0]     x_end;
    logic [CW1-1:0]     y_end;
    logic               in_x;
    logic               in_y;
    logic               hit_c;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] col_f;
    logic [COORD_W-1:0] row;
    logic [FRM_W-1:0]   eff;
    logic [ADDR_W-1:0]  addr_c;

    // Right/bottom edges get an extra bit so a sprite near 2^COORD_W does not wrap.
    always_comb begin
        x_end  = {1'b0, attr.x} + SPR_W_C;
        y_end  = {1'b0, attr.y} + SPR_H_C;
        in_x   = (draw_x >= attr.x) && ({1'b0, draw_x} < x_end);
        in_y   = (draw_y >= attr.y) && ({1'b0, draw_y} < y_end);
        hit_c  = attr.vis && in_x && in_y;
        col    = draw_x - attr.x;
        row    = draw_y - attr.y;
        col_f  = attr.flip ? (COL_MAX - col) : col;
        eff    = eff_frame(attr.frame, attr.anim, phase, NUM_FRAMES);
        addr_c = ADDR_W'(eff) * FRAME_SZ + ADDR_W'(row) * ROW_SZ + ADDR_W'(col_f);
    end

    assign rom_addr = hit_c ? addr_c : '0;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_c;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: double-buffered attribute banks, animation counters,
// per-channel address generation and a transparency/priority stage with 2-cycle latency.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int               NUM_SPR    = DEF_NUM_SPR,
    parameter int               SPR_W      = DEF_SPR_W,
    parameter int               SPR_H      = DEF_SPR_H,
    parameter int               NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int               COORD_W    = DEF_COORD_W,
    parameter int               COLOR_W    = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 24'hFF00FF,
    parameter int               ANIM_LEN   = 3,
    parameter int               ANIM_DIV   = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    sprite_compositor_if.slave bus
);

    localparam int DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DIV_LAST_I = ANIM_DIV - 1;
    localparam int PH_LAST_I  = ANIM_LEN - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_LAST_I[DIV_W-1:0];
    localparam logic [FRM_W-1:0] PH_LAST  = PH_LAST_I[FRM_W-1:0];

    spr_attr_t         pend     [NUM_SPR];
    spr_attr_t         pend_nxt [NUM_SPR];
    spr_attr_t         act      [NUM_SPR];
    spr_attr_t         wr_attr;
    logic [DIV_W-1:0]  div_cnt;
    logic [FRM_W-1:0]  phase;
    logic [NUM_SPR-1:0] hit_q;
    logic [ADDR_W-1:0] ch_addr  [NUM_SPR];

    logic               win_hit;
    logic [IDX_W-1:0]   win_id;
    logic [COLOR_W-1:0] win_color;
    logic [COLOR_W-1:0] texel;

    always_comb begin
        wr_attr       = '0;
        wr_attr.x     = bus.wr_x;
        wr_attr.y     = bus.wr_y;
        wr_attr.frame = bus.wr_frame;
        wr_attr.flip  = bus.wr_flip;
        wr_attr.vis   = bus.wr_vis;
        wr_attr.anim  = bus.wr_anim;
    end

    // The active copy takes pend_nxt so a write coinciding with frame_start lands immediately.
    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) begin
            pend_nxt[i] = pend[i];
            if (bus.wr_en && (bus.wr_idx == IDX_W'(i))) begin
                pend_nxt[i] = wr_attr;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
            div_cnt <= '0;
            phase   <= '0;
        end else begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pend[i] <= pend_nxt[i];
            end
            if (bus.frame_start) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    act[i] <= pend_nxt[i];
                end
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    phase   <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_ch
        sprite_channel #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_FRAMES (NUM_FRAMES),
            .COORD_W    (COORD_W)
        ) u_ch (
            .Clk      (Clk),
            .Reset_n  (Reset_n),
            .attr     (act[g]),
            .phase    (phase),
            .draw_x   (bus.DrawX),
            .draw_y   (bus.DrawY),
            .hit      (hit_q[g]),
            .rom_addr (ch_addr[g])
        );
    end

    always_comb begin
        bus.rom_addr = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            bus.rom_addr[i*ADDR_W +: ADDR_W] = ch_addr[i];
        end
    end

    // Scan from the lowest priority up so the lowest-index opaque channel is the last to write.
    always_comb begin
        win_hit   = 1'b0;
        win_id    = '0;
        win_color = '0;
        texel     = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            texel = bus.rom_data[i*COLOR_W +: COLOR_W];
            if (hit_q[i] && (texel != KEY_COLOR)) begin
                win_hit   = 1'b1;
                win_id    = IDX_W'(i);
                win_color = texel;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.spr_hit   <= 1'b0;
            bus.spr_id    <= '0;
            bus.spr_color <= '0;
        end else begin
            bus.spr_hit   <= win_hit;
            bus.spr_id    <= win_id;
            bus.spr_color <= win_color;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a texel = address ROM model per channel.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam logic [9:0]  MISS = 10'd1023;
    localparam logic [23:0] KEY  = 24'hFF00FF;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  key_mask = 4'b0000;
    logic [23:0] rom_q [4];

    always #5 Clk = ~Clk;

    sprite_compositor_if bus ();

    sprite_compositor dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // External synchronous ROMs: one-cycle read, texel equals its own address unless keyed.
    always @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            rom_q[i] <= key_mask[i] ? KEY : 24'(bus.rom_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        bus.rom_data = '0;
        for (int i = 0; i < 4; i++) begin
            bus.rom_data[i*24 +: 24] = rom_q[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eh, input logic [1:0] eid,
                           input logic [23:0] ecol);
        chk({tag, ".hit"},   32'(bus.spr_hit),   32'(eh));
        chk({tag, ".id"},    32'(bus.spr_id),    32'(eid));
        chk({tag, ".color"}, 32'(bus.spr_color), 32'(ecol));
    endtask

    task automatic wr(input logic [1:0] idx, input logic [9:0] x, input logic [9:0] y,
                      input logic [2:0] frame, input logic flip, input logic vis,
                      input logic anim, input logic fs);
        @(negedge Clk);
        bus.wr_idx = idx; bus.wr_x = x; bus.wr_y = y; bus.wr_frame = frame;
        bus.wr_flip = flip; bus.wr_vis = vis; bus.wr_anim = anim;
        bus.wr_en = 1'b1; bus.frame_start = fs;
        @(negedge Clk);
        bus.wr_en = 1'b0; bus.frame_start = 1'b0;
    endtask

    task automatic fs_pulse();
        @(negedge Clk);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic settle();
        @(negedge Clk);
        bus.DrawX = MISS; bus.DrawY = MISS;
        repeat (3) @(posedge Clk);
    endtask

    // Called at a negedge with a miss pixel in flight: presents one pixel for one cycle
    // and checks nothing shows after one edge and the result shows after exactly two.
    task automatic pulse_body(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic eh, input logic [1:0] eid, input logic [23:0] ecol);
        bus.DrawX = x; bus.DrawY = y;
        @(negedge Clk);
        chk({tag, ".early"}, 32'(bus.spr_hit), 32'd0);
        bus.DrawX = MISS; bus.DrawY = MISS;
        @(posedge Clk); #1;
        chk_out(tag, eh, eid, ecol);
        repeat (2) @(posedge Clk);
    endtask

    task automatic pulse_px(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic eh, input logic [1:0] eid, input logic [23:0] ecol);
        @(negedge Clk);
        pulse_body(tag, x, y, eh, eid, ecol);
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0;
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_frame = '0;
        bus.wr_flip = 1'b0; bus.wr_vis = 1'b0; bus.wr_anim = 1'b0;
        bus.DrawX = MISS; bus.DrawY = MISS;

        // Reset state
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk); #1;
        chk_out("reset", 1'b0, 2'd0, 24'd0);
        chk("reset.rom_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Sweep with nothing written
        for (int yi = 0; yi < 3; yi++) begin
            for (int xi = 0; xi < 4; xi++) begin
                @(negedge Clk);
                bus.DrawX = (xi == 0) ? 10'd0 : (xi == 1) ? 10'd100 : (xi == 2) ? 10'd125 : 10'd639;
                bus.DrawY = (yi == 0) ? 10'd0 : (yi == 1) ? 10'd200 : 10'd479;
                #1;
                chk("sweep.rom_addr", 32'(bus.rom_addr), 32'd0);
                repeat (2) @(posedge Clk); #1;
                chk("sweep.hit", 32'(bus.spr_hit), 32'd0);
            end
        end
        settle();

        // Channel 0 at (100,200), frame 0
        wr(2'd0, 10'd100, 10'd200, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_px("c0_tl",    10'd100, 10'd200, 1'b1, 2'd0, 24'd0);
        pulse_px("c0_br",    10'd125, 10'd231, 1'b1, 2'd0, 24'd831);
        pulse_px("c0_right", 10'd126, 10'd200, 1'b0, 2'd0, 24'd0);
        pulse_px("c0_below", 10'd100, 10'd232, 1'b0, 2'd0, 24'd0);
        pulse_px("c0_left",  10'd99,  10'd200, 1'b0, 2'd0, 24'd0);
        @(negedge Clk);
        bus.DrawX = 10'd110; bus.DrawY = 10'd205;
        #1;
        chk("c0_addr", 32'(bus.rom_addr[ADDR_W-1:0]), 32'd140);
        settle();

        // Horizontal flip
        wr(2'd0, 10'd100, 10'd200, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        pulse_px("flip_tl", 10'd100, 10'd200, 1'b1, 2'd0, 24'd25);
        pulse_px("flip_br", 10'd125, 10'd231, 1'b1, 2'd0, 24'd806);

        // Overlap with channel 1 (frame 1)
        wr(2'd1, 10'd100, 10'd200, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        key_mask = 4'b0001;
        pulse_px("ovl_key", 10'd100, 10'd200, 1'b1, 2'd1, 24'd832);
        key_mask = 4'b0011;
        pulse_px("ovl_allkey", 10'd100, 10'd200, 1'b0, 2'd0, 24'd0);
        key_mask = 4'b0000;
        pulse_px("ovl_opq", 10'd100, 10'd200, 1'b1, 2'd0, 24'd25);

        // Pending write alone does not reach the active set
        wr(2'd0, 10'd100, 10'd200, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_px("pend_only", 10'd100, 10'd200, 1'b1, 2'd0, 24'd25);

        // Write-through: write with frame_start, pixel in the very next cycle
        @(negedge Clk);
        bus.wr_idx = 2'd0; bus.wr_x = 10'd300; bus.wr_y = 10'd300; bus.wr_frame = 3'd0;
        bus.wr_flip = 1'b0; bus.wr_vis = 1'b1; bus.wr_anim = 1'b0;
        bus.wr_en = 1'b1; bus.frame_start = 1'b1;
        @(negedge Clk);
        bus.wr_en = 1'b0; bus.frame_start = 1'b0;
        pulse_body("wt_next", 10'd301, 10'd301, 1'b1, 2'd0, 24'd27);
        pulse_px("wt_ch1", 10'd100, 10'd200, 1'b1, 2'd1, 24'd832);

        // Animation from a clean counter state
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        wr(2'd0, 10'd100, 10'd200, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        pulse_px("anim_p1", 10'd101, 10'd200, 1'b1, 2'd0, 24'd5825);
        repeat (4) fs_pulse();
        pulse_px("anim_p5", 10'd101, 10'd200, 1'b1, 2'd0, 24'd5825);
        fs_pulse();
        pulse_px("anim_p6", 10'd101, 10'd200, 1'b1, 2'd0, 24'd1);
        repeat (6) fs_pulse();
        pulse_px("anim_p12", 10'd101, 10'd200, 1'b1, 2'd0, 24'd833);
        repeat (6) fs_pulse();
        pulse_px("anim_p18", 10'd101, 10'd200, 1'b1, 2'd0, 24'd5825);
        repeat (6) fs_pulse();
        pulse_px("anim_p24", 10'd101, 10'd200, 1'b1, 2'd0, 24'd1);

        // Reset in the middle of a frame while the sprite is on screen
        @(negedge Clk);
        bus.DrawX = 10'd101; bus.DrawY = 10'd200;
        repeat (3) @(posedge Clk); #1;
        chk("pre_rst.hit", 32'(bus.spr_hit), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        chk_out("in_rst", 1'b0, 2'd0, 24'd0);
        chk("in_rst.rom_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk); #1;
        chk("rst_hidden.hit", 32'(bus.spr_hit), 32'd0);
        settle();
        wr(2'd0, 10'd100, 10'd200, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        pulse_px("rst_phase", 10'd101, 10'd200, 1'b1, 2'd0, 24'd5825);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
